// File: rtl/gb_pkg.sv
// gb_pkg: shared Game Boy core types.
// pc_mod select codes, dispatch states, IRQ bit indices.
package gb_pkg;

  localparam logic [2:0] PC_SEL_PC      = 3'd0;
  localparam logic [2:0] PC_SEL_INCR    = 3'd1;
  localparam logic [2:0] PC_SEL_RST     = 3'd2;
  localparam logic [2:0] PC_SEL_INT     = 3'd3;
  localparam logic [2:0] PC_SEL_ZERO    = 3'd4;
  localparam logic [2:0] PC_SEL_DBUS    = 3'd5;
  localparam logic [2:0] PC_SEL_DBUS_RL = 3'd6;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_STAT   = 1;
  localparam int IRQ_TIMER  = 2;
  localparam int IRQ_SERIAL = 3;
  localparam int IRQ_JOYPAD = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W1   = 3'd1,
    ST_W2   = 3'd2,
    ST_PH   = 3'd3,
    ST_PL   = 3'd4,
    ST_JP   = 3'd5
  } disp_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-set-bit priority encoder.
// Bit 0 has the highest priority.
module irq_prio_enc #(
  parameter int N = 5
) (
  input  logic [N-1:0] req,
  output logic [2:0]   index,
  output logic         any
);

  // scan high to low so the lowest set bit wins
  always_comb begin
    index = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) index = 3'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/int_dispatch.sv
// int_dispatch: IF/IE/IME state and interrupt dispatch sequencer.
// INT_LATE_VECTOR_EN: re-pick the vector at the low-byte push.
module int_dispatch
  import gb_pkg::*;
#(
  parameter int NUM_IRQ = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               instr_boundary,
  input  logic               ime_set,
  input  logic               ime_clr,
  input  logic               reg_wr,
  input  logic               reg_sel,
  input  logic [7:0]         reg_wdata,
  input  logic [15:0]        pc,
  input  logic               push_ready,
  output logic [7:0]         if_out,
  output logic [7:0]         ie_out,
  output logic               ime,
  output logic               int_take,
  output logic               busy,
  output logic               push_valid,
  output logic [7:0]         push_data,
  output logic [2:0]         pc_sel,
  output logic [2:0]         int_pc_in,
  output logic               halt_wake
);

  disp_state_t        state;
  logic [NUM_IRQ-1:0] if_q;
  logic [7:0]         ie_q;
  logic               ime_q;
  logic               ime_pend;
  logic [2:0]         vec;
  logic               vec_ok;
  logic               push_hi;
  logic [NUM_IRQ-1:0] pend;
  logic [2:0]         pend_idx;
  logic               pend_any;
  logic [NUM_IRQ-1:0] clr_mask;
  logic               idle;
  logic               xfer;

  assign pend = if_q & ie_q[NUM_IRQ-1:0];

  irq_prio_enc #(
    .N(NUM_IRQ)
  ) u_prio (
    .req  (pend),
    .index(pend_idx),
    .any  (pend_any)
  );

  assign idle = (state == ST_IDLE);

  // the boundary that moves EI into IME must not dispatch
  assign int_take = idle & instr_boundary & ime_q
                  & ~ime_pend & pend_any;

  assign xfer = idle & instr_boundary & ime_pend;

  // dispatch acknowledges only the latched bit, in the jump cycle
  always_comb begin
    clr_mask = '0;
    if (state == ST_JP && vec_ok)
      clr_mask = {{(NUM_IRQ-1){1'b0}}, 1'b1} << vec;
  end

  // IF/IE registers; peripheral pulses override writes and clears
  always_ff @(posedge clock) begin
    if (reset) begin
      if_q <= '0;
      ie_q <= '0;
    end else begin
      if (reg_wr && reg_sel)
        ie_q <= reg_wdata;
      if_q <= (((reg_wr && !reg_sel) ? reg_wdata[NUM_IRQ-1:0] : if_q)
               & ~clr_mask) | irq_in;
    end
  end

  // IME with one-instruction EI delay; DI wins over EI
  always_ff @(posedge clock) begin
    if (reset) begin
      ime_q    <= 1'b0;
      ime_pend <= 1'b0;
    end else if (ime_clr) begin
      ime_q    <= 1'b0;
      ime_pend <= 1'b0;
    end else begin
      if (int_take) begin
        ime_q <= 1'b0;
      end else if (xfer) begin
        ime_q    <= 1'b1;
        ime_pend <= 1'b0;
      end
      if (ime_set)
        ime_pend <= 1'b1;
    end
  end

  // dispatch sequencer: wait, wait, push hi, push lo, jump
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      vec        <= 3'd0;
      vec_ok     <= 1'b0;
      busy       <= 1'b0;
      push_valid <= 1'b0;
      push_hi    <= 1'b0;
      pc_sel     <= PC_SEL_PC;
      int_pc_in  <= 3'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (int_take) begin
            state  <= ST_W1;
            vec    <= pend_idx;
            vec_ok <= 1'b1;
            busy   <= 1'b1;
          end
        end
        ST_W1: state <= ST_W2;
        ST_W2: begin
          state      <= ST_PH;
          push_valid <= 1'b1;
          push_hi    <= 1'b1;
        end
        ST_PH: begin
          if (push_ready) begin
            state   <= ST_PL;
            push_hi <= 1'b0;
          end
        end
        ST_PL: begin
          if (push_ready) begin
            state      <= ST_JP;
            push_valid <= 1'b0;
`ifdef INT_LATE_VECTOR_EN
            vec        <= pend_idx;
            vec_ok     <= pend_any;
            pc_sel     <= pend_any ? PC_SEL_INT : PC_SEL_ZERO;
            int_pc_in  <= pend_any ? pend_idx : 3'd0;
`else
            pc_sel     <= PC_SEL_INT;
            int_pc_in  <= vec;
`endif
          end
        end
        ST_JP: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          pc_sel    <= PC_SEL_PC;
          int_pc_in <= 3'd0;
        end
        default: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          push_valid <= 1'b0;
          push_hi    <= 1'b0;
          pc_sel     <= PC_SEL_PC;
          int_pc_in  <= 3'd0;
        end
      endcase
    end
  end

  assign push_data = !push_valid ? 8'h00 :
                     push_hi ? pc[15:8] : pc[7:0];

  assign if_out    = {{(8-NUM_IRQ){1'b1}}, if_q};
  assign ie_out    = ie_q;
  assign ime       = ime_q;
  assign halt_wake = pend_any;

endmodule

// File: tb/tb_int_dispatch.sv
// tb_int_dispatch: table, directed and random checks of int_dispatch.
// Reference model tracks dispatch as a cycle phase count.
module tb_int_dispatch;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  irq_in;
  logic        instr_boundary;
  logic        ime_set;
  logic        ime_clr;
  logic        reg_wr;
  logic        reg_sel;
  logic [7:0]  reg_wdata;
  logic [15:0] pc;
  logic        push_ready;
  logic [7:0]  if_out;
  logic [7:0]  ie_out;
  logic        ime;
  logic        int_take;
  logic        busy;
  logic        push_valid;
  logic [7:0]  push_data;
  logic [2:0]  pc_sel;
  logic [2:0]  int_pc_in;
  logic        halt_wake;

  always #5 clock = ~clock;

  int_dispatch #(.NUM_IRQ(5)) dut (
    .clock(clock), .reset(reset), .irq_in(irq_in),
    .instr_boundary(instr_boundary), .ime_set(ime_set),
    .ime_clr(ime_clr), .reg_wr(reg_wr), .reg_sel(reg_sel),
    .reg_wdata(reg_wdata), .pc(pc), .push_ready(push_ready),
    .if_out(if_out), .ie_out(ie_out), .ime(ime),
    .int_take(int_take), .busy(busy), .push_valid(push_valid),
    .push_data(push_data), .pc_sel(pc_sel),
    .int_pc_in(int_pc_in), .halt_wake(halt_wake)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [4:0] m_if;
  logic [7:0] m_ie;
  logic       m_ime;
  logic       m_pend;
  int         m_ph;
  int         m_vec;
  logic       m_vok;

  typedef struct packed {
    logic        bnd;
    logic        iset;
    logic        wr;
    logic        sel;
    logic [7:0]  wd;
    logic [4:0]  irq;
    logic        e_take;
    logic        e_busy;
    logic        e_pv;
    logic [7:0]  e_pd;
    logic [2:0]  e_ps;
    logic [2:0]  e_ip;
    logic [7:0]  e_if;
    logic        e_ime;
  } row_t;

  row_t tbl[12];

  function automatic int lowest(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [34:0] dut_out();
    return {int_take, busy, push_valid, push_data, pc_sel,
            int_pc_in, if_out, ie_out, ime, halt_wake};
  endfunction

  function automatic logic model_take();
    logic [4:0] p;
    p = m_if & m_ie[4:0];
    return (m_ph == 0) && instr_boundary && m_ime && !m_pend
           && (p != 5'd0);
  endfunction

  function automatic logic [34:0] model_out();
    logic [4:0] p;
    logic [7:0] pd;
    logic [2:0] ps;
    logic [2:0] ip;
    p  = m_if & m_ie[4:0];
    pd = (m_ph == 3) ? pc[15:8] : (m_ph == 4) ? pc[7:0] : 8'h00;
    ps = (m_ph == 5) ? (m_vok ? 3'd3 : 3'd4) : 3'd0;
    ip = (m_ph == 5 && m_vok) ? 3'(m_vec) : 3'd0;
    return {model_take(), m_ph != 0, m_ph == 3 || m_ph == 4, pd, ps,
            ip, 3'b111, m_if, m_ie, m_ime, p != 5'd0};
  endfunction

  task automatic model_step();
    logic [4:0] p;
    logic [4:0] clr;
    logic       tk;
    p   = m_if & m_ie[4:0];
    tk  = model_take();
    clr = 5'd0;
    if (reset) begin
      m_if = 5'd0; m_ie = 8'd0; m_ime = 1'b0; m_pend = 1'b0;
      m_ph = 0; m_vec = 0; m_vok = 1'b0;
      return;
    end
    if (m_ph == 5 && m_vok) clr[m_vec] = 1'b1;
    if (ime_clr) begin
      m_ime = 1'b0; m_pend = 1'b0;
    end else begin
      if (tk) m_ime = 1'b0;
      else if (m_ph == 0 && instr_boundary && m_pend) begin
        m_ime = 1'b1; m_pend = 1'b0;
      end
      if (ime_set) m_pend = 1'b1;
    end
    if (reg_wr && reg_sel) m_ie = reg_wdata;
    m_if = (((reg_wr && !reg_sel) ? reg_wdata[4:0] : m_if) & ~clr)
           | irq_in;
    case (m_ph)
      0: if (tk) begin m_ph = 1; m_vec = lowest(p); m_vok = 1'b1; end
      1, 2: m_ph = m_ph + 1;
      3: if (push_ready) m_ph = 4;
      4: if (push_ready) begin
        m_ph = 5;
`ifdef INT_LATE_VECTOR_EN
        m_vok = (p != 5'd0);
        m_vec = lowest(p);
`endif
      end
      default: m_ph = 0;
    endcase
  endtask

  task automatic check(input string name, input logic [39:0] act,
                       input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit chk = 1'b1);
    logic [34:0] e;
    logic [34:0] a;
    @(negedge clock);
    e = model_out();
    a = dut_out();
    if (chk) begin
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL model t=%0t dut=%h expected=%h", $time, a, e);
      end
    end
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic clr_in();
    reset = 1'b0; irq_in = 5'd0; instr_boundary = 1'b0;
    ime_set = 1'b0; ime_clr = 1'b0; reg_wr = 1'b0;
    reg_sel = 1'b0; reg_wdata = 8'd0; push_ready = 1'b1;
  endtask

  task automatic enable_ime();
    clr_in(); ime_set = 1'b1; cyc();
    clr_in(); instr_boundary = 1'b1; cyc();
    clr_in();
  endtask

  task automatic raise(input logic [4:0] b);
    clr_in(); irq_in = b; cyc(); clr_in();
  endtask

  task automatic take_now();
    clr_in(); instr_boundary = 1'b1;
    #1 check("take_fires", 40'(int_take), 40'd1);
    cyc(); clr_in();
  endtask

  initial begin
    clr_in();
    pc = 16'h1234;
    m_if = 5'd0; m_ie = 8'd0; m_ime = 1'b0; m_pend = 1'b0;
    m_ph = 0; m_vec = 0; m_vok = 1'b0;

    //     bnd  iset wr   sel  wd     irq    tk   bsy  pv   pd     ps    ip    if     ime
    tbl[0]  = {1'b0,1'b0,1'b0,1'b0,8'h00,5'h00,1'b0,1'b0,1'b0,8'h00,3'd0,3'd0,8'hE0,1'b0};
    tbl[1]  = {1'b0,1'b0,1'b1,1'b1,8'h01,5'h00,1'b0,1'b0,1'b0,8'h00,3'd0,3'd0,8'hE0,1'b0};
    tbl[2]  = {1'b0,1'b1,1'b0,1'b0,8'h00,5'h00,1'b0,1'b0,1'b0,8'h00,3'd0,3'd0,8'hE0,1'b0};
    tbl[3]  = {1'b1,1'b0,1'b0,1'b0,8'h00,5'h00,1'b0,1'b0,1'b0,8'h00,3'd0,3'd0,8'hE0,1'b0};
    tbl[4]  = {1'b0,1'b0,1'b0,1'b0,8'h00,5'h01,1'b0,1'b0,1'b0,8'h00,3'd0,3'd0,8'hE0,1'b1};
    tbl[5]  = {1'b1,1'b0,1'b0,1'b0,8'h00,5'h00,1'b1,1'b0,1'b0,8'h00,3'd0,3'd0,8'hE1,1'b1};
    tbl[6]  = {1'b1,1'b0,1'b0,1'b0,8'h00,5'h00,1'b0,1'b1,1'b0,8'h00,3'd0,3'd0,8'hE1,1'b0};
    tbl[7]  = {1'b0,1'b0,1'b0,1'b0,8'h00,5'h00,1'b0,1'b1,1'b0,8'h00,3'd0,3'd0,8'hE1,1'b0};
    tbl[8]  = {1'b0,1'b0,1'b0,1'b0,8'h00,5'h00,1'b0,1'b1,1'b1,8'h12,3'd0,3'd0,8'hE1,1'b0};
    tbl[9]  = {1'b0,1'b0,1'b0,1'b0,8'h00,5'h00,1'b0,1'b1,1'b1,8'h34,3'd0,3'd0,8'hE1,1'b0};
    tbl[10] = {1'b0,1'b0,1'b0,1'b0,8'h00,5'h00,1'b0,1'b1,1'b0,8'h00,3'd3,3'd0,8'hE1,1'b0};
    tbl[11] = {1'b0,1'b0,1'b0,1'b0,8'h00,5'h00,1'b0,1'b0,1'b0,8'h00,3'd0,3'd0,8'hE0,1'b0};

    reset = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    clr_in();

    for (int i = 0; i < 12; i++) begin
      clr_in();
      instr_boundary = tbl[i].bnd;
      ime_set = tbl[i].iset;
      reg_wr = tbl[i].wr;
      reg_sel = tbl[i].sel;
      reg_wdata = tbl[i].wd;
      irq_in = tbl[i].irq;
      #3;
      check($sformatf("tbl_row%0d", i),
            40'({int_take, busy, push_valid, push_data, pc_sel,
                 int_pc_in, if_out, ime}),
            40'({tbl[i].e_take, tbl[i].e_busy, tbl[i].e_pv,
                 tbl[i].e_pd, tbl[i].e_ps, tbl[i].e_ip,
                 tbl[i].e_if, tbl[i].e_ime}));
      cyc();
    end
    clr_in();

    // timer beats joypad
    reg_wr = 1'b1; reg_sel = 1'b0; reg_wdata = 8'h14; cyc();
    reg_sel = 1'b1; reg_wdata = 8'h1F; cyc();
    enable_ime();
    take_now();
    for (int n = 0; n < 10 && pc_sel == 3'd0; n++) cyc();
    check("timer_pc_sel", 40'(pc_sel), 40'd3);
    check("timer_vec", 40'(int_pc_in), 40'd2);
    cyc();
    check("timer_if_out", 40'(if_out), 40'hF0);

    // three push_ready stalls in PH push JP to T+8
    enable_ime();
    pc = 16'hABCD;
    take_now();
    for (int k = 1; k <= 7; k++) begin
      push_ready = !(k >= 3 && k <= 5);
      #1;
      if (k == 5)
        check("stall_hi_held", 40'({push_valid, push_data}),
              40'({1'b1, 8'hAB}));
      cyc();
    end
    push_ready = 1'b1;
    check("stall_jp_t8", 40'({pc_sel, int_pc_in}),
          40'({3'd3, 3'd4}));
    cyc();

    // EI takes effect one boundary late
    raise(5'h01);
    ime_set = 1'b1; cyc(); clr_in();
    instr_boundary = 1'b1;
    #1 check("ei_first_bnd", 40'(int_take), 40'd0);
    cyc();
    take_now();
    repeat (5) cyc();
    ime_set = 1'b1; ime_clr = 1'b1; cyc(); clr_in();
    instr_boundary = 1'b1; cyc();
    check("di_wins_over_ei", 40'(ime), 40'd0);

    // IF cleared by write during PH
    raise(5'h01);
    enable_ime();
    take_now();
    cyc(); cyc();
    reg_wr = 1'b1; reg_sel = 1'b0; reg_wdata = 8'h00; cyc();
    clr_in(); cyc();
`ifdef INT_LATE_VECTOR_EN
    check("late_pc_sel", 40'(pc_sel), 40'd4);
`else
    check("late_pc_sel", 40'({pc_sel, int_pc_in}), 40'({3'd3, 3'd0}));
`endif
    cyc();
    check("late_if_out", 40'(if_out), 40'hE0);

    // new request in the JP cycle survives the clear
    raise(5'h01);
    enable_ime();
    take_now();
    repeat (4) cyc();
    irq_in = 5'h01; cyc(); clr_in();
    check("jp_irq_wins", 40'(if_out), 40'hE1);

    // reset in PL
    enable_ime();
    take_now();
    repeat (3) cyc();
    reset = 1'b1; cyc(); clr_in();
    check("rst_in_pl", 40'({push_valid, busy, pc_sel, if_out, ie_out}),
          40'({1'b0, 1'b0, 3'd0, 8'hE0, 8'h00}));

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      irq_in = ($urandom_range(7) == 0) ? 5'($urandom) : 5'd0;
      instr_boundary = ($urandom_range(2) == 0);
      ime_set = ($urandom_range(5) == 0);
      ime_clr = ($urandom_range(24) == 0);
      reg_wr = ($urandom_range(9) == 0);
      reg_sel = 1'($urandom);
      reg_wdata = 8'($urandom);
      pc = 16'($urandom);
      push_ready = ($urandom_range(3) != 0);
      reset = ($urandom_range(499) == 0);
      cyc();
    end
    clr_in();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/int_dispatch.md
# int_dispatch

Interrupt controller and dispatch sequencer for the Game Boy CPU core. It holds the IF, IE and IME interrupt state and picks the highest-priority pending interrupt at an instruction boundary. It then runs the five-step dispatch: two wait cycles, push PC high byte, push PC low byte, jump through `pc_mod`. It drives `pc_mod`'s `pc_sel`/`int_pc_in` directly and hands the pushes to the core's stack/memory path.

## Interface
Parameters:
- `NUM_IRQ`, 5: number of interrupt sources; bit 0 is highest priority (VBlank, STAT, Timer, Serial, Joypad).

Ports (one clock; reset is synchronous and active-high):
- `clock` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `irq_in` in 5: one-cycle request pulses from peripherals; each sets its IF bit.
- `instr_boundary` in 1: core is at an opcode-fetch decision point this cycle.
- `ime_set` in 1: EI/RETI executed.
- `ime_clr` in 1: DI executed.
- `reg_wr` in 1: register write strobe.
- `reg_sel` in 1: 0 = IF ($FF0F), 1 = IE ($FFFF).
- `reg_wdata` in 8: write data.
- `pc` in 16: current PC from `pc_mod`.
- `push_ready` in 1: stack write accepted this cycle.
- `if_out` out 8: {3'b111, IF[4:0]}.
- `ie_out` out 8: IE register, all 8 bits stored.
- `ime` out 1: interrupt master enable.
- `int_take` out 1: combinational; dispatch starts this cycle, so the core suppresses its fetch.
- `busy` out 1: dispatch in progress; the core stalls.
- `push_valid` out 1: `push_data` is valid.
- `push_data` out 8: byte to push.
- `pc_sel` out 3: to `pc_mod`; 0 = hold, 3 = int vector, 4 = zero.
- `int_pc_in` out 3: vector index 0..4, giving $40/$48/$50/$58/$60.
- `halt_wake` out 1: combinational |(IF & IE[4:0]), independent of IME.

## Operation
Reset values:
- All outputs low except `if_out` = 8'hE0.
- IF = 0, IE = 0, IME = 0, `ime_pending` = 0, state IDLE, `pc_sel` = 0.
- Reset in any state returns to IDLE next edge; no partial push completes.

IF update, per edge:
- IF_next = (write ? wdata[4:0] : IF) & ~clr_mask | `irq_in`.
- A peripheral set always wins over a register write or a dispatch clear in the same cycle.

IME:
- `ime_clr` clears IME and `ime_pending` immediately; it wins over `ime_set`.
- `ime_set` sets `ime_pending`.
- On the next `instr_boundary` edge, `ime_pending` moves to IME.
- EI therefore enables interrupts one instruction late.
- The boundary that performs the transfer does not itself dispatch.

Take condition, evaluated in IDLE:
- `instr_boundary` & IME & |(IF & IE[4:0]).
- On take: `int_take` = 1, IME is cleared, the lowest-index pending bit is latched as `vec`, and the next state is W1.

States:
- IDLE: wait for the take condition.
- W1 -> W2: unconditional, one cycle each.
- W2 -> PH: unconditional.
- PH: `push_valid` = 1, `push_data` = `pc[15:8]`; move to PL on `push_ready`, otherwise hold.
- PL: `push_valid` = 1, `push_data` = `pc[7:0]`; move to JP on `push_ready`.
- JP: `pc_sel` = 3, `int_pc_in` = `vec`, clear IF[`vec`]; return to IDLE.

Outputs and inputs during dispatch:
- `busy` = 1 in W1..JP.
- `pc_sel` = 0 in every state except JP.
- `ime_set` during W1..JP is recorded into `ime_pending`.
- `instr_boundary` is ignored while busy.

## Timing
- Take at cycle T with `push_ready` tied high: W1 at T+1, W2 at T+2, PH at T+3, PL at T+4, JP at T+5.
- PC equals the vector after the T+5 edge; IDLE and `busy` = 0 at T+6.
- Minimum dispatch is 5 cycles with `busy` high; each `push_ready` stall adds one cycle.
- Back-to-back: a take may occur at T+6 if IME was re-enabled and the boundary asserted.

## Configuration
Macro `INT_LATE_VECTOR_EN`.

Defined (hardware quirk):
- `vec` is re-evaluated at the PL edge from the current IF & IE.
- If nothing is pending then, JP drives `pc_sel` = 4 (PC = $0000) and clears no IF bit.

Undefined:
- `vec` stays as latched at take.
- JP always jumps to that vector and clears that bit.

## Structure
- Shared package `gb_pkg` holds:
  - the `pc_sel` encodings (PC 0, INCR 1, RST 2, INT 3, ZERO 4, DATA_BUS 5, DATA_BUS_REL 6);
  - the dispatch state enum;
  - the IRQ bit indices.
- One sub-module, `irq_prio_enc`: combinational 5-bit lowest-set-bit priority encoder giving `index[2:0]` and `any`.

## Test plan
- Reset, then IE = $01, IME on, `irq_in` = 5'b00001, boundary with `pc` = $1234 -> pushes $12 then $34, `pc_sel` = 3 with `int_pc_in` = 0 at T+5, `busy` for 5 cycles, IF = $E0, `ime` = 0.
- IF = 5'b10100, IE = $1F -> `int_pc_in` = 2 (Timer, $50); only IF bit 2 cleared, `if_out` = $F0.
- `push_ready` held low 3 cycles in PH -> `push_data` = `pc[15:8]` held; JP at T+8.
- EI (`ime_set`) with a pending request -> no take on the first boundary; take on the second; `ime_clr` together with `ime_set` -> `ime` stays 0.
- With the macro on: during PH, write IF = 0 -> JP drives `pc_sel` = 4 and IF stays 0. With it off, the same stimulus -> `pc_sel` = 3 to the latched vector.
- `irq_in` bit 0 in the JP cycle that clears bit 0 -> IF bit 0 remains 1. Reset asserted in PL -> IDLE, `push_valid` = 0, IF = 0 on the next cycle.
